// File: rtl/pea_pkg.sv
// Shared definitions for the PEA token feeder and the PEA command decoder.
// State encodings, command token field positions and the stall limit.
package pea_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WR_CMD,
        S_WR_DATA,
        S_DONE
    } state_t;

    localparam int OPC_LSB  = 8;
    localparam int OPC_W    = 8;
    localparam int ARG1_LSB = 5;
    localparam int ARG1_W   = 3;
    localparam int ARG2_LSB = 0;
    localparam int ARG2_W   = 5;

    localparam int TIMEOUT_LIMIT = 255;

endpackage

// File: rtl/pea_token_pack.sv
// Packs opcode/arg1/arg2 into a command token; shared with the PEA decoder
// so both ends agree on field placement.
module pea_token_pack
    import pea_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic [OPC_W-1:0]     opcode,
    input  logic [ARG1_W-1:0]    arg1,
    input  logic [ARG2_W-1:0]    arg2,
    output logic [WORD_SIZE-1:0] token
);

    always_comb begin
        token = '0;
        token[OPC_LSB +: OPC_W]   = opcode;
        token[ARG1_LSB +: ARG1_W] = arg1;
        token[ARG2_LSB +: ARG2_W] = arg2;
    end

endmodule

// File: rtl/pea_token_feeder.sv
// Host-side producer of command/data tokens for the PEA input FIFOs.
// Optional host stall timeout with zero padding: PEA_FEEDER_TIMEOUT_EN.
module pea_token_feeder
    import pea_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int BUFFER_SIZE = 1024,
    parameter int MAX_COUNT   = 31,
    localparam int COUNT_W    = $clog2(MAX_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OPC_W-1:0]     req_instr,
    input  logic [ARG1_W-1:0]    req_arg1,
    input  logic [ARG2_W-1:0]    req_arg2,
    input  logic [COUNT_W-1:0]   req_count,
    input  logic [WORD_SIZE-1:0] host_data,
    input  logic                 host_data_valid,
    output logic                 host_data_ready,
    input  logic [WORD_SIZE-1:0] command_free_space,
    input  logic [WORD_SIZE-1:0] data_free_space,
    output logic                 wr_command,
    output logic [WORD_SIZE-1:0] command_out,
    output logic                 wr_data,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout
);

    localparam logic [WORD_SIZE-1:0] BUF_WORDS = WORD_SIZE'(BUFFER_SIZE);

    state_t               state, state_n;
    logic [COUNT_W-1:0]   rem, rem_n;
    logic [WORD_SIZE-1:0] cmd_n;
    logic [WORD_SIZE-1:0] token;
    logic [WORD_SIZE-1:0] dspace;
    logic                 space_ok;

    pea_token_pack #(
        .WORD_SIZE(WORD_SIZE)
    ) u_pack (
        .opcode(req_instr),
        .arg1  (req_arg1),
        .arg2  (req_arg2),
        .token (token)
    );

    // Reports above the FIFO depth are treated as a full-depth FIFO.
    assign dspace = (data_free_space > BUF_WORDS) ? BUF_WORDS
                                                  : data_free_space;

    assign space_ok = (command_free_space != '0) &&
        (dspace >= {{(WORD_SIZE-COUNT_W){1'b0}}, rem});

`ifdef PEA_FEEDER_TIMEOUT_EN
    localparam logic [7:0] STALL_MAX = 8'(TIMEOUT_LIMIT);

    logic [7:0] stall;
    logic       err_q;
    logic       pad;

    assign pad = (state == S_WR_DATA) && (stall == STALL_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall <= '0;
            err_q <= 1'b0;
        end else begin
            if (state != S_WR_DATA || (host_data_valid && !pad)) begin
                stall <= '0;
            end else if (!pad) begin
                stall <= stall + 8'd1;
            end
            if (pad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            rem         <= '0;
            command_out <= '0;
        end else begin
            state       <= state_n;
            rem         <= rem_n;
            command_out <= cmd_n;
        end
    end

    always_comb begin
        state_n         = state;
        rem_n           = rem;
        cmd_n           = command_out;
        req_ready       = 1'b0;
        host_data_ready = 1'b0;
        wr_command      = 1'b0;
        wr_data         = 1'b0;
        data_out        = '0;
        done            = 1'b0;

        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cmd_n   = token;
                    rem_n   = req_count;
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                if (space_ok) begin
                    state_n = S_WR_CMD;
                end
            end
            S_WR_CMD: begin
                wr_command = 1'b1;
                state_n    = (rem == '0) ? S_DONE : S_WR_DATA;
            end
            S_WR_DATA: begin
`ifdef PEA_FEEDER_TIMEOUT_EN
                if (pad) begin
                    wr_data = 1'b1;
                end else begin
                    host_data_ready = 1'b1;
                    wr_data         = host_data_valid;
                    data_out        = host_data;
                end
`else
                host_data_ready = 1'b1;
                wr_data         = host_data_valid;
                data_out        = host_data;
`endif
                if (wr_data) begin
                    rem_n = rem - COUNT_W'(1);
                    if (rem == COUNT_W'(1)) begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_pea_token_feeder.sv
// Self-checking bench for pea_token_feeder: directed and random requests
// compared against a transaction-level model of the token stream.
module tb_pea_token_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_instr = '0;
    logic [2:0]  req_arg1 = '0;
    logic [4:0]  req_arg2 = '0;
    logic [4:0]  req_count = '0;
    logic [15:0] host_data = '0;
    logic        host_data_valid = 1'b0;
    logic        host_data_ready;
    logic [15:0] command_free_space = 16'd1024;
    logic [15:0] data_free_space = 16'd1024;
    logic        wr_command;
    logic [15:0] command_out;
    logic        wr_data;
    logic [15:0] data_out;
    logic        busy;
    logic        done;
    logic        err_timeout;

    pea_token_feeder dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_instr         (req_instr),
        .req_arg1          (req_arg1),
        .req_arg2          (req_arg2),
        .req_count         (req_count),
        .host_data         (host_data),
        .host_data_valid   (host_data_valid),
        .host_data_ready   (host_data_ready),
        .command_free_space(command_free_space),
        .data_free_space   (data_free_space),
        .wr_command        (wr_command),
        .command_out       (command_out),
        .wr_data           (wr_data),
        .data_out          (data_out),
        .busy              (busy),
        .done              (done),
        .err_timeout       (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total = 0;

    logic [15:0] tx_q[$];
    logic [15:0] dat_log[$];
    int          wr_cyc[$];
    int          acc, cmd_cyc, done_cyc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One request; the model says: one command token once space suffices,
    // then the queued words in order (zeros from pad_from on), then done.
    task automatic run_req(input logic [7:0] ins, input logic [2:0] a1,
                           input logic [4:0] a2, input int cfs0,
                           input int dfs0, input int raise_after,
                           input int valid_pct, input int gap_at,
                           input int gap_len, input int pad_from);
        logic [15:0] cmd_log[$];
        int n, idx, ok_cyc, last_wr, done_n, gap_left, k;
        bit both, early, bad;
        logic [15:0] expw;
        n = tx_q.size();
        idx = 0; ok_cyc = -1; last_wr = -1; done_n = 0;
        gap_left = gap_len; both = 0; early = 0; bad = 0;
        acc = -1; cmd_cyc = -1; done_cyc = -1;
        dat_log.delete();
        wr_cyc.delete();
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_instr = ins; req_arg1 = a1; req_arg2 = a2;
        req_count = 5'(n);
        command_free_space = 16'(cfs0);
        data_free_space = 16'(dfs0);
        host_data_valid = 1'b0;
        k = 0;
        while (done_n == 0 && k < 2000) begin
            @(negedge clk);
            if (acc < 0 && req_ready && req_valid) acc = cyc;
            if (acc >= 0 && cyc > acc && ok_cyc < 0 &&
                command_free_space >= 1 && data_free_space >= n)
                ok_cyc = cyc;
            if ((wr_command || wr_data) && ok_cyc < 0) early = 1;
            if (wr_command && wr_data) both = 1;
            if (wr_data && host_data_ready && !host_data_valid) bad = 1;
            if (wr_command) begin
                cmd_log.push_back(command_out);
                cmd_cyc = cyc;
            end
            if (wr_data) begin
                dat_log.push_back(data_out);
                wr_cyc.push_back(cyc);
                last_wr = cyc;
            end
            if (host_data_ready && host_data_valid) idx++;
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            @(posedge clk); #1;
            if (acc >= 0) req_valid = 1'b0;
            if (acc >= 0 && cyc - acc >= raise_after) begin
                command_free_space = 16'd1024;
                data_free_space = 16'd1024;
            end
            if (idx < n) begin
                if (idx == gap_at && gap_left > 0) begin
                    gap_left--;
                    host_data_valid = 1'b0;
                end else begin
                    host_data_valid = ($urandom_range(99) < valid_pct);
                end
                host_data = host_data_valid ? tx_q[idx] : 16'($urandom);
            end else begin
                host_data_valid = 1'b0;
            end
            k++;
        end
        @(negedge clk);
        chk("done_once", done_n + (done ? 1 : 0), 1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_ready", req_ready, 1'b1);
        chk("cmd_count", cmd_log.size(), 1);
        chk("cmd_token", cmd_log.size() > 0 ? cmd_log[0] : 16'hxxxx,
            {ins, a1, a2});
        chk("cmd_cycle", cmd_cyc, ok_cyc + 1);
        chk("no_early", early, 1'b0);
        chk("no_overlap", both, 1'b0);
        chk("no_invalid_wr", bad, 1'b0);
        chk("data_count", dat_log.size(), n);
        for (int i = 0; i < n; i++) begin
            expw = (i >= pad_from) ? 16'h0000 : tx_q[i];
            chk($sformatf("data[%0d]", i),
                i < dat_log.size() ? dat_log[i] : 16'hxxxx, expw);
        end
        chk("done_cycle", done_cyc,
            (n == 0) ? cmd_cyc + 1 : last_wr + 1);
    endtask

    task automatic fill_rand(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(16'($urandom));
    endtask

    initial begin
        int idx;
        bit accd;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_cmd", wr_command, 1'b0);
        chk("rst_wr_data", wr_data, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cmd_out", command_out, 16'h0000);
        chk("rst_err", err_timeout, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Basic four-word request, host streams back to back.
        tx_q = '{16'd5, 16'hFFFE, 16'd7, 16'd1};
        run_req(8'h01, 3'd3, 5'd4, 1024, 1024, 0, 100, -1, 0, 99);
        chk("basic_lat", cmd_cyc - acc, 2);
        chk("basic_token", {req_instr, req_arg1, req_arg2}, 16'h0164);
        chk("basic_burst", wr_cyc.size() == 4 ? wr_cyc[3] - wr_cyc[0] : -1,
            3);

        // Zero-count request.
        tx_q.delete();
        run_req(8'h05, 3'd0, 5'd0, 1024, 1024, 0, 100, -1, 0, 99);
        chk("zero_done_lat", done_cyc - acc, 3);

        // Data FIFO short by one word, then enough.
        fill_rand(3);
        run_req(8'hA5, 3'd1, 5'd9, 1024, 2, 6, 100, -1, 0, 99);
        chk("dspace_wait", cmd_cyc - acc, 7);

        // Command FIFO full, then one slot frees.
        fill_rand(1);
        run_req(8'h3C, 3'd7, 5'd31, 0, 1024, 5, 100, -1, 0, 99);
        chk("cspace_wait", cmd_cyc - acc, 6);

        // Ten-cycle host gap mid-stream.
        fill_rand(6);
        run_req(8'h11, 3'd2, 5'd3, 1024, 1024, 0, 100, 2, 10, 99);
        chk("gap_span", wr_cyc.size() == 6 ? wr_cyc[2] - wr_cyc[1] : -1,
            11);

        // Random requests, fields, space and host pacing.
        for (int t = 0; t < 6; t++) begin
            fill_rand($urandom_range(31));
            run_req(8'($urandom), 3'($urandom), 5'($urandom),
                    $urandom_range(1), $urandom_range(40),
                    $urandom_range(1, 8), $urandom_range(30, 100),
                    -1, 0, 99);
        end

        // Reset in the middle of a four-word stream.
        fill_rand(4);
        idx = 0;
        accd = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_count = 5'd4;
        host_data_valid = 1'b1;
        host_data = tx_q[0];
        for (int k = 0; k < 50 && idx < 2; k++) begin
            @(negedge clk);
            if (req_ready && req_valid) accd = 1;
            if (host_data_ready && host_data_valid) idx++;
            @(posedge clk); #1;
            if (accd) req_valid = 1'b0;
            host_data = tx_q[idx];
        end
        chk("abort_reached", idx, 2);
        #1;
        chk("abort_pre_wr", wr_data, 1'b1);
        chk("abort_pre_data", data_out, tx_q[2]);
        rst = 1'b0;
        #1;
        chk("abort_wr_data", wr_data, 1'b0);
        chk("abort_wr_cmd", wr_command, 1'b0);
        chk("abort_data_out", data_out, 16'h0000);
        chk("abort_cmd_out", command_out, 16'h0000);
        chk("abort_done", done, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", req_ready, 1'b1);
        chk("abort_hdr", host_data_ready, 1'b0);
        host_data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

`ifdef PEA_FEEDER_TIMEOUT_EN
        // Host stalls after one word of three; two zero pads follow.
        fill_rand(3);
        run_req(8'h77, 3'd5, 5'd2, 1024, 1024, 0, 100, 1, 1000, 1);
        chk("to_err", err_timeout, 1'b1);
        chk("to_delay", wr_cyc.size() == 3 ? wr_cyc[1] - wr_cyc[0] : -1,
            256);
        chk("to_pad_gap", wr_cyc.size() == 3 ? wr_cyc[2] - wr_cyc[1] : -1,
            1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
